// File: rtl/clip_record_play_ctrl_if.sv
// Sample-RAM bus between the record/play controller (master) and the clip RAM (slave).
// Address is {clip, offset}; read data is valid one cycle after memRe.
interface clip_record_play_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 14
);
    logic [ADDR_W:0]   memAddr;
    logic              memWe;
    logic              memRe;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;

    modport master (
        output memAddr, memWe, memRe, memWdata,
        input  memRdata
    );

    modport slave (
        input  memAddr, memWe, memRe, memWdata,
        output memRdata
    );
endinterface

// File: rtl/clip_record_play_ctrl.sv
// Two-clip record/playback sequencer: paces mic writes and speaker reads at the sample rate,
// keeps per-clip lengths and valid flags, and handles clip selection from button pulses.
module clip_record_play_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned CLIP_DEPTH = 16000,
    parameter int unsigned SAMPLE_DIV = 3125
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  playPulse,
    input  logic                  recordPulse,
    input  logic                  clipPlayPulse,
    input  logic                  clipRecordPulse,
    input  logic                  resetPulse,
    input  logic [DATA_W-1:0]     micSample,
    clip_record_play_ctrl_if.master mem,
    output logic [DATA_W-1:0]     spkSample,
    output logic                  spkValid,
    output logic                  playClip,
    output logic                  recClip,
    output logic [1:0]            clipValid,
    output logic                  recording,
    output logic                  playing,
    output logic                  doneStrobe
);

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(CLIP_DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W + 1)'(CLIP_DEPTH);

    typedef enum logic [1:0] {StIdle, StRecord, StPlay} stateT;

    stateT               stateQ, stateD;
    logic [DIV_W-1:0]    divQ, divD;
    logic [ADDR_W-1:0]   offsetQ, offsetD;
    logic [1:0][ADDR_W:0] lenQ, lenD;
    logic [1:0]          clipValidQ, clipValidD;
    logic                playClipQ, playClipD;
    logic                recClipQ, recClipD;
    logic [ADDR_W:0]     memAddrQ, memAddrD;
    logic                memWeQ, memWeD;
    logic                memReQ, memReD;
    logic [DATA_W-1:0]   memWdataQ, memWdataD;
    // Read pipeline: memRe -> rdValid (RAM data present) -> spkValid; "last" flags ride along.
    logic                lastReQ, lastReD;
    logic                rdValidQ, rdValidD;
    logic                lastRdQ, lastRdD;
    logic [DATA_W-1:0]   spkSampleQ, spkSampleD;
    logic                spkValidQ, spkValidD;
    logic                spkLastQ, spkLastD;
    logic                doneQ, doneD;

    logic                tick;
    logic [ADDR_W:0]     wrLen;
    logic [ADDR_W:0]     playLast;

    assign tick     = (stateQ != StIdle) && (divQ == DIV_LAST);
    // A write strobed this cycle has not bumped the offset yet, so count it here.
    assign wrLen    = {1'b0, offsetQ} + {{ADDR_W{1'b0}}, memWeQ};
    assign playLast = lenQ[playClipQ] - (ADDR_W + 1)'(1);

    always_comb begin
        stateD     = stateQ;
        divD       = (stateQ == StIdle || tick) ? '0 : divQ + DIV_W'(1);
        offsetD    = offsetQ;
        lenD       = lenQ;
        clipValidD = clipValidQ;
        playClipD  = playClipQ;
        recClipD   = recClipQ;
        memAddrD   = memAddrQ;
        memWeD     = 1'b0;
        memReD     = 1'b0;
        memWdataD  = memWdataQ;
        lastReD    = 1'b0;
        rdValidD   = 1'b0;
        lastRdD    = 1'b0;
        spkSampleD = spkSampleQ;
        spkValidD  = 1'b0;
        spkLastD   = 1'b0;
        doneD      = 1'b0;

        if (resetPulse) begin
            stateD     = StIdle;
            divD       = '0;
            offsetD    = '0;
            lenD       = '0;
            clipValidD = '0;
            playClipD  = 1'b0;
            recClipD   = 1'b0;
            memAddrD   = '0;
            spkSampleD = '0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (recordPulse) begin
                        stateD                = StRecord;
                        divD                  = '0;
                        offsetD               = '0;
                        clipValidD[recClipQ]  = 1'b0;
                    end else if (playPulse && clipValidQ[playClipQ]) begin
                        stateD  = StPlay;
                        divD    = '0;
                        offsetD = '0;
                    end else begin
                        if (clipPlayPulse)   playClipD = ~playClipQ;
                        if (clipRecordPulse) recClipD  = ~recClipQ;
                    end
                end
                StRecord: begin
                    if (recordPulse || (memWeQ && offsetQ == LAST_OFF)) begin
                        // A tick coinciding with the stop pulse is dropped: no write follows.
                        stateD               = StIdle;
                        divD                 = '0;
                        doneD                = 1'b1;
                        lenD[recClipQ]       = recordPulse ? wrLen : FULL_LEN;
                        clipValidD[recClipQ] = recordPulse ? (wrLen != '0) : 1'b1;
                    end else begin
                        if (memWeQ) offsetD = offsetQ + ADDR_W'(1);
                        if (tick) begin
                            memWeD    = 1'b1;
                            memAddrD  = {recClipQ, offsetQ};
                            memWdataD = micSample;
                        end
                    end
                end
                StPlay: begin
                    if (playPulse || (spkValidQ && spkLastQ)) begin
                        stateD = StIdle;
                        divD   = '0;
                        doneD  = 1'b1;
                    end else begin
                        if (tick) begin
                            memReD   = 1'b1;
                            memAddrD = {playClipQ, offsetQ};
                            lastReD  = ({1'b0, offsetQ} == playLast);
                        end
                        if (memReQ) begin
                            rdValidD = 1'b1;
                            lastRdD  = lastReQ;
                            if (!lastReQ) offsetD = offsetQ + ADDR_W'(1);
                        end
                        if (rdValidQ) begin
                            spkSampleD = mem.memRdata;
                            spkValidD  = 1'b1;
                            spkLastD   = lastRdQ;
                        end
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ     <= StIdle;
            divQ       <= '0;
            offsetQ    <= '0;
            lenQ       <= '0;
            clipValidQ <= '0;
            playClipQ  <= 1'b0;
            recClipQ   <= 1'b0;
            memAddrQ   <= '0;
            memWeQ     <= 1'b0;
            memReQ     <= 1'b0;
            memWdataQ  <= '0;
            lastReQ    <= 1'b0;
            rdValidQ   <= 1'b0;
            lastRdQ    <= 1'b0;
            spkSampleQ <= '0;
            spkValidQ  <= 1'b0;
            spkLastQ   <= 1'b0;
            doneQ      <= 1'b0;
        end else begin
            stateQ     <= stateD;
            divQ       <= divD;
            offsetQ    <= offsetD;
            lenQ       <= lenD;
            clipValidQ <= clipValidD;
            playClipQ  <= playClipD;
            recClipQ   <= recClipD;
            memAddrQ   <= memAddrD;
            memWeQ     <= memWeD;
            memReQ     <= memReD;
            memWdataQ  <= memWdataD;
            lastReQ    <= lastReD;
            rdValidQ   <= rdValidD;
            lastRdQ    <= lastRdD;
            spkSampleQ <= spkSampleD;
            spkValidQ  <= spkValidD;
            spkLastQ   <= spkLastD;
            doneQ      <= doneD;
        end
    end

    assign mem.memAddr  = memAddrQ;
    assign mem.memWe    = memWeQ;
    assign mem.memRe    = memReQ;
    assign mem.memWdata = memWdataQ;
    assign spkSample    = spkSampleQ;
    assign spkValid     = spkValidQ;
    assign playClip     = playClipQ;
    assign recClip      = recClipQ;
    assign clipValid    = clipValidQ;
    assign recording    = (stateQ == StRecord);
    assign playing      = (stateQ == StPlay);
    assign doneStrobe   = doneQ;

endmodule
